// File: rtl/sram_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sram_bus_arbiter : CPU/ICD sharing of the external SRAM bus (setup/strobe/hold)
// Optional: SRAM_ARB_ROUNDROBIN_EN alternates grants on simultaneous requests
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sram_bus_arbiter #(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic        clk6x,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_rwn,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        icd_req,
  input  logic        icd_rwn,
  input  logic [20:0] icd_addr,
  input  logic [7:0]  icd_wdata,
  output logic        icd_ack,
  output logic [7:0]  icd_rdata,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wdata_oe,
  input  logic [7:0]  mem_rdata,
  output logic        m1cs_n,
  output logic        mrd_n,
  output logic        mwr_n,
  output logic        busy
);

  localparam int MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

`ifdef SRAM_ARB_ROUNDROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rwn;
  logic             r_gnt_cpu;
  logic             r_last_cpu;
  logic             r_cpu_ack;
  logic             r_icd_ack;
  logic [7:0]       r_cpu_rdata;
  logic [7:0]       r_icd_rdata;
  logic [20:0]      r_mem_addr;
  logic [7:0]       r_mem_wdata;
  logic             r_oe;
  logic             r_cs_n;
  logic             r_rd_n;
  logic             r_wr_n;

  logic w_any_req;
  logic w_pick_cpu;
  logic w_rwn;

  // CPU wins unless both request and rotation says it is the ICD's turn
  assign w_any_req  = cpu_req | icd_req;
  assign w_pick_cpu = cpu_req & (~icd_req | ~RR_EN | ~r_last_cpu);
  assign w_rwn      = w_pick_cpu ? cpu_rwn : icd_rwn;

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rwn       <= 1'b1;
      r_gnt_cpu   <= 1'b0;
      r_last_cpu  <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_icd_ack   <= 1'b0;
      r_cpu_rdata <= 8'h00;
      r_icd_rdata <= 8'h00;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_oe        <= 1'b0;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
    end else begin
      r_cpu_ack <= 1'b0;
      r_icd_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_cpu   <= w_pick_cpu;
            r_last_cpu  <= w_pick_cpu;
            r_rwn       <= w_rwn;
            r_mem_addr  <= w_pick_cpu ? cpu_addr : icd_addr;
            r_mem_wdata <= w_pick_cpu ? cpu_wdata : icd_wdata;
            r_cnt       <= w_rwn ? RD_LOAD : WR_LOAD;
            r_cs_n      <= 1'b0;
            r_oe        <= ~w_rwn;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_rwn) r_rd_n <= 1'b0;
          else       r_wr_n <= 1'b0;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_rd_n <= 1'b1;
            r_wr_n <= 1'b1;
            // Sample read data at the end of the last strobe cycle
            if (r_rwn && r_gnt_cpu)  r_cpu_rdata <= mem_rdata;
            if (r_rwn && !r_gnt_cpu) r_icd_rdata <= mem_rdata;
            r_cpu_ack <= r_gnt_cpu;
            r_icd_ack <= ~r_gnt_cpu;
            r_state   <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          r_cs_n  <= 1'b1;
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_ack      = r_cpu_ack;
  assign icd_ack      = r_icd_ack;
  assign cpu_rdata    = r_cpu_rdata;
  assign icd_rdata    = r_icd_rdata;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wdata_oe = r_oe;
  assign m1cs_n       = r_cs_n;
  assign mrd_n        = r_rd_n;
  assign mwr_n        = r_wr_n;
  assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire
